rom_load_sequencer: RTL and testbench

// - Sits between the SD-card loader's ROM byte stream (dout/dout_valid) and the NES memory write port.
// - Parses the 16-byte iNES header and skips the optional 512-byte trainer.
// - Writes PRG bytes from address 0 and CHR bytes from CHR_BASE, one write per memory handshake.
// - A small FIFO absorbs the stream while memory is busy. Publishes mapper/size/mirroring and done/fail status.

---
 rtl/rom_load_sequencer_pkg.sv | 68 ++++++
 rtl/rom_byte_fifo.sv | 84 ++++++++
 rtl/rom_load_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_rom_load_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_load_sequencer_pkg.sv
// Shared constants, types and helpers for the iNES ROM load sequencer.
// Holds iNES magic bytes, header field offsets, flag bit positions, state and fail encodings.
// Also holds the PRG/CHR unit shift amounts and the length helpers built from them.
package rom_load_sequencer_pkg;

    // Byte counter width; large enough for any PRG or CHR region length.
    localparam int CNT_W = 22;

    // iNES header layout.
    localparam int HDR_LEN    = 16;
    localparam int OFS_PRG    = 4;
    localparam int OFS_CHR    = 5;
    localparam int OFS_FLAGS6 = 6;
    localparam int OFS_FLAGS7 = 7;

    localparam logic [7:0] INES_MAGIC0 = 8'h4E;  // 'N'
    localparam logic [7:0] INES_MAGIC1 = 8'h45;  // 'E'
    localparam logic [7:0] INES_MAGIC2 = 8'h53;  // 'S'
    localparam logic [7:0] INES_MAGIC3 = 8'h1A;  // EOF

    // Flags 6 bit positions.
    localparam int FLAG6_MIRROR  = 0;
    localparam int FLAG6_BATTERY = 1;
    localparam int FLAG6_TRAINER = 2;

    localparam int TRAIN_LEN = 512;

    // PRG is counted in 16 KB units, CHR in 8 KB units.
    localparam int PRG_SHIFT = 14;
    localparam int CHR_SHIFT = 13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_TRAIN = 3'd2,
        ST_PRG   = 3'd3,
        ST_CHR   = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        FAIL_MAGIC    = 2'd0,
        FAIL_PRG_SIZE = 2'd1,
        FAIL_OVERFLOW = 2'd2
    } fail_code_t;

    function automatic logic [7:0] ines_magic(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INES_MAGIC0;
            2'd1:    b = INES_MAGIC1;
            2'd2:    b = INES_MAGIC2;
            default: b = INES_MAGIC3;
        endcase
        return b;
    endfunction

    // Region lengths in bytes; 8-bit unit counts can never overflow CNT_W.
    function automatic logic [CNT_W-1:0] prg_bytes(input logic [7:0] units);
        return CNT_W'({units, {PRG_SHIFT{1'b0}}});
    endfunction

    function automatic logic [CNT_W-1:0] chr_bytes(input logic [7:0] units);
        return CNT_W'({units, {CHR_SHIFT{1'b0}}});
    endfunction

endpackage

// File: rtl/rom_byte_fifo.sv
// Byte FIFO between the ROM stream and the memory write port, registered full/empty flags.
// Latency: a pushed byte is visible on pop_data the cycle after the push (combinational read of head).
// Backpressure: none upstream; a push while full is dropped unless a pop happens the same cycle.
//
// Ports: clk/resetn (async active-low); flush empties the FIFO synchronously and, if push is
// also high, leaves exactly that byte at the head; push/push_data write side; pop/pop_data read
// side (pop on empty is ignored); full/empty status.
module rom_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = push ? (AW+1)'(1) : '0;
        end else if (do_push && !do_pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= push ? AW'(1) : '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // Storage carries no reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (flush && push) begin
            mem[0] <= push_data;
        end else if (!flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/rom_load_sequencer.sv
// Parses an iNES image from the SD loader byte stream and writes PRG/CHR bytes to memory.
// Latency: one cycle from FIFO pop to mem_req; with mem_ack held high, one write per cycle.
// Backpressure: the stream cannot be stalled; a FIFO overflow aborts the load with fail_code 2.
//
// Ports: clk, resetn (async active-low); load_start restarts from any state; din/din_valid is
// the ROM byte stream; mem_req/mem_addr/mem_data/mem_ack is the held-until-ack write port;
// mapper/prg_units/chr_units/mirroring/battery are header fields; busy/done/fail/fail_code status.
module rom_load_sequencer
    import rom_load_sequencer_pkg::*;
#(
    parameter int                FIFO_DEPTH = 16,
    parameter int                ADDR_W     = 22,
    parameter logic [ADDR_W-1:0] CHR_BASE   = 'h200000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_start,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic [7:0]        mapper,
    output logic [7:0]        prg_units,
    output logic [7:0]        chr_units,
    output logic              mirroring,
    output logic              battery,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [1:0]        fail_code
);

    localparam logic [CNT_W-1:0] CHR_BASE_CNT = CNT_W'(CHR_BASE);

    state_t           state;
    state_t           state_nxt;
    fail_code_t       fail_code_q;
    fail_code_t       fail_code_nxt;
    logic [CNT_W-1:0] cnt;

    logic [3:0]       map_lo;
    logic [3:0]       map_hi;
    logic             trainer;

    logic             fifo_flush;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    logic             in_load;
    logic             in_write;
    logic             write_slot;
    logic             overflow;
    logic             write_done;
    logic [CNT_W-1:0] prg_len;
    logic [CNT_W-1:0] chr_len;
    logic [CNT_W-1:0] region_len;
    logic [ADDR_W-1:0] region_base;

    assign in_load  = state inside {ST_HDR, ST_TRAIN, ST_PRG, ST_CHR};
    assign in_write = state inside {ST_PRG, ST_CHR};

    assign prg_len     = prg_bytes(prg_units);
    assign chr_len     = chr_bytes(chr_units);
    assign region_len  = (state == ST_CHR) ? chr_len : prg_len;
    assign region_base = (state == ST_CHR) ? CHR_BASE : '0;

    // load_start may carry header byte 0 in the same cycle; the flush keeps just that byte.
    assign fifo_push  = din_valid && (in_load || load_start);
    // The write register can take a new byte when empty or being drained this cycle.
    assign write_slot = !mem_req || mem_ack;

    rom_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fail_code_nxt = fail_code_q;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;
        overflow      = 1'b0;
        write_done    = 1'b0;

        case (state)
            ST_HDR, ST_TRAIN: fifo_pop = !fifo_empty;
            // Bytes beyond the current region stay queued for the next region.
            ST_PRG, ST_CHR:   fifo_pop = !fifo_empty && (cnt < region_len) && write_slot;
            default:          fifo_pop = 1'b0;
        endcase

        overflow   = in_load && fifo_push && fifo_full && !fifo_pop;
        // Once every byte of the region is issued, the outstanding request is the last one.
        write_done = in_write && mem_req && mem_ack && (cnt == region_len);

        if (load_start) begin
            state_nxt  = ST_HDR;
            fifo_flush = 1'b1;
            fifo_pop   = 1'b0;
        end else begin
            case (state)
                ST_HDR: begin
                    if (overflow) begin
                        state_nxt     = ST_FAIL;
                        fail_code_nxt = FAIL_OVERFLOW;
                    end else if (fifo_pop) begin
                        if (cnt < CNT_W'(4) && fifo_dout != ines_magic(cnt[1:0])) begin
                            state_nxt     = ST_FAIL;
                            fail_code_nxt = FAIL_MAGIC;
                        end else if (cnt == CNT_W'(HDR_LEN - 1)) begin
                            if (prg_units == 8'd0 || prg_len > CHR_BASE_CNT) begin
                                state_nxt     = ST_FAIL;
                                fail_code_nxt = FAIL_PRG_SIZE;
                            end else if (trainer) begin
                                state_nxt = ST_TRAIN;
                            end else begin
                                state_nxt = ST_PRG;
                            end
                        end
                    end
                end
                ST_TRAIN: begin
                    if (overflow) begin
                        state_nxt     = ST_FAIL;
                        fail_code_nxt = FAIL_OVERFLOW;
                    end else if (fifo_pop && cnt == CNT_W'(TRAIN_LEN - 1)) begin
                        state_nxt = ST_PRG;
                    end
                end
                ST_PRG: begin
                    if (overflow) begin
                        state_nxt     = ST_FAIL;
                        fail_code_nxt = FAIL_OVERFLOW;
                    end else if (write_done) begin
                        state_nxt = (chr_units != 8'd0) ? ST_CHR : ST_DONE;
                    end
                end
                ST_CHR: begin
                    if (overflow) begin
                        state_nxt     = ST_FAIL;
                        fail_code_nxt = FAIL_OVERFLOW;
                    end else if (write_done) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: begin
                    // IDLE, DONE, FAIL: nothing in flight, trailing stream bytes are discarded.
                    fifo_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            prg_units   <= '0;
            chr_units   <= '0;
            map_lo      <= '0;
            map_hi      <= '0;
            mirroring   <= 1'b0;
            battery     <= 1'b0;
            trainer     <= 1'b0;
            fail_code_q <= FAIL_MAGIC;
        end else if (load_start) begin
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            prg_units   <= '0;
            chr_units   <= '0;
            map_lo      <= '0;
            map_hi      <= '0;
            mirroring   <= 1'b0;
            battery     <= 1'b0;
            trainer     <= 1'b0;
            fail_code_q <= FAIL_MAGIC;
        end else begin
            // The counter is per-phase: header index, trainer index, then bytes issued.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (fifo_pop) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == ST_HDR && fifo_pop) begin
                case (cnt[3:0])
                    4'(OFS_PRG): prg_units <= fifo_dout;
                    4'(OFS_CHR): chr_units <= fifo_dout;
                    4'(OFS_FLAGS6): begin
                        map_lo    <= fifo_dout[7:4];
                        trainer   <= fifo_dout[FLAG6_TRAINER];
                        battery   <= fifo_dout[FLAG6_BATTERY];
                        mirroring <= fifo_dout[FLAG6_MIRROR];
                    end
                    4'(OFS_FLAGS7): map_hi <= fifo_dout[7:4];
                    default: ;
                endcase
            end

            if (state_nxt == ST_DONE || state_nxt == ST_FAIL) begin
                mem_req <= 1'b0;
            end else if (fifo_pop && in_write) begin
                mem_req  <= 1'b1;
                mem_addr <= region_base + ADDR_W'(cnt);
                mem_data <= fifo_dout;
            end else if (mem_ack) begin
                mem_req <= 1'b0;
            end

            if (state_nxt == ST_FAIL && state != ST_FAIL) begin
                fail_code_q <= fail_code_nxt;
            end
        end
    end

    assign mapper    = {map_hi, map_lo};
    assign busy      = in_load;
    assign done      = (state == ST_DONE);
    assign fail      = (state == ST_FAIL);
    assign fail_code = fail_code_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer: valid image, bad magic, trainer skip, FIFO overflow,
// short memory stall, load_start restart and asynchronous reset mid-CHR.
// Writes are checked one by one against the image the bench builds.
module tb_rom_load_sequencer;

    localparam int ADDR_W     = 22;
    localparam int CHR_BASE_I = 32'h200000;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              load_start = 1'b0;
    logic [7:0]        din = 8'h00;
    logic              din_valid = 1'b0;
    logic              mem_ack = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [7:0]        mapper;
    logic [7:0]        prg_units;
    logic [7:0]        chr_units;
    logic              mirroring;
    logic              battery;
    logic              busy;
    logic              done;
    logic              fail;
    logic [1:0]        fail_code;

    rom_load_sequencer #(
        .FIFO_DEPTH (16),
        .ADDR_W     (ADDR_W),
        .CHR_BASE   (22'h200000)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load_start (load_start),
        .din        (din),
        .din_valid  (din_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .mapper     (mapper),
        .prg_units  (prg_units),
        .chr_units  (chr_units),
        .mirroring  (mirroring),
        .battery    (battery),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_code  (fail_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  img[$];
    logic [7:0]  exp_data[$];
    int          exp_prg_len;
    int          wr_count;
    bit          req_seen;
    logic [31:0] first_addr;
    logic [31:0] prg_last_addr;
    logic [31:0] chr_first_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int k);
        if (k < exp_prg_len) return 32'(k);
        return 32'(CHR_BASE_I + k - exp_prg_len);
    endfunction

    // Called after inputs are driven: a write completes at the coming edge iff mem_req && mem_ack.
    task automatic sample_wr();
        if (mem_req) req_seen = 1'b1;
        if (mem_req && mem_ack) begin
            if (wr_count < exp_data.size()) begin
                check("wr_addr", 32'(mem_addr), exp_addr(wr_count));
                check("wr_data", 32'(mem_data), 32'(exp_data[wr_count]));
            end else begin
                check("wr_extra", 32'(wr_count), 32'(exp_data.size()));
            end
            if (wr_count == 0) first_addr = 32'(mem_addr);
            if (wr_count == exp_prg_len - 1) prg_last_addr = 32'(mem_addr);
            if (wr_count == exp_prg_len) chr_first_addr = 32'(mem_addr);
            wr_count++;
        end
    endtask

    task automatic tick();
        sample_wr();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input logic [7:0] m3, input logic [7:0] h6, input logic [7:0] h7,
                         input int prg, input int chr, input int seed);
        logic [7:0] b;
        img.delete();
        exp_data.delete();
        wr_count       = 0;
        req_seen       = 1'b0;
        first_addr     = '1;
        prg_last_addr  = '1;
        chr_first_addr = '1;
        exp_prg_len    = prg * 16384;
        img.push_back(8'h4E); img.push_back(8'h45); img.push_back(8'h53); img.push_back(m3);
        img.push_back(8'(prg)); img.push_back(8'(chr)); img.push_back(h6); img.push_back(h7);
        for (int i = 0; i < 8; i++) img.push_back(8'h00);
        if (h6[2]) begin
            for (int i = 0; i < 512; i++) img.push_back(8'hA5 ^ 8'(i));
        end
        for (int i = 0; i < prg * 16384 + chr * 8192; i++) begin
            b = 8'(i * 13 + seed + (i >> 8));
            img.push_back(b);
            exp_data.push_back(b);
        end
    endtask

    task automatic start_load(input bit with_byte);
        load_start = 1'b1;
        din_valid  = with_byte;
        din        = 8'h4E;
        mem_ack    = 1'b1;
        tick();
        load_start = 1'b0;
        din_valid  = 1'b0;
    endtask

    // Streams img one byte per cycle; mem_ack low for run cycles [stall_at, stall_at+stall_len).
    task automatic run(input int stall_at, input int stall_len, input int stop_after,
                       input int budget, output int cycles);
        int sent = 0;
        int cyc  = 0;
        bit fin  = 1'b0;
        while (!fin) begin
            if (img.size() > 0 && (stop_after < 0 || sent < stop_after)) begin
                din       = img.pop_front();
                din_valid = 1'b1;
                sent++;
            end else begin
                din_valid = 1'b0;
            end
            mem_ack = !(cyc >= stall_at && cyc < stall_at + stall_len);
            tick();
            cyc++;
            din_valid = 1'b0;
            if (stop_after >= 0 && sent >= stop_after) begin
                fin = 1'b1;
            end else if (img.size() == 0 && (done || fail)) begin
                fin = 1'b1;
            end else if (cyc >= budget) begin
                check("run_timeout", 32'(done | fail), 32'd1);
                fin = 1'b1;
            end
        end
        mem_ack = 1'b1;
        cycles  = cyc;
    endtask

    initial begin
        int cyc;

        // Reset state
        build(8'h1A, 8'h00, 8'h00, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mapper", 32'(mapper), 32'd0);
        check("rst_status", 32'({busy, done, fail, fail_code}), 32'd0);
        resetn = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // 1) valid image: 1x16K PRG + 1x8K CHR, mem_ack always high
        start_load(1'b0);
        build(8'h1A, 8'h03, 8'h00, 1, 1, 0);
        run(0, 0, -1, 30000, cyc);
        check("t1_done", 32'(done), 32'd1);
        check("t1_fail", 32'(fail), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_writes", 32'(wr_count), 32'd24576);
        check("t1_first_addr", first_addr, 32'h0);
        check("t1_prg_last", prg_last_addr, 32'h003FFF);
        check("t1_chr_first", chr_first_addr, 32'h200000);
        check("t1_mapper", 32'(mapper), 32'h00);
        check("t1_units", 32'({prg_units, chr_units}), 32'h0101);
        check("t1_flags", 32'({mirroring, battery}), 32'b11);
        check("t1_throughput", 32'(cyc <= 24600), 32'd1);

        // 2) bad magic, header byte 0 delivered with load_start
        start_load(1'b1);
        build(8'h1B, 8'h00, 8'h00, 0, 0, 0);
        void'(img.pop_front());
        run(0, 0, -1, 200, cyc);
        check("t2_fail", 32'(fail), 32'd1);
        check("t2_code", 32'(fail_code), 32'd0);
        check("t2_done", 32'(done), 32'd0);
        check("t2_no_req", 32'(req_seen), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);

        // 3) trainer present, mapper 1, CHR-RAM
        start_load(1'b0);
        build(8'h1A, 8'h14, 8'h00, 1, 0, 7);
        run(0, 0, -1, 20000, cyc);
        check("t3_done", 32'(done), 32'd1);
        check("t3_mapper", 32'(mapper), 32'h01);
        check("t3_writes", 32'(wr_count), 32'd16384);
        check("t3_first_addr", first_addr, 32'h0);
        check("t3_prg_last", prg_last_addr, 32'h003FFF);
        check("t3_chr_units", 32'(chr_units), 32'd0);

        // 4) memory stalled 20 cycles during PRG -> overflow
        start_load(1'b0);
        build(8'h1A, 8'h00, 8'h00, 1, 0, 3);
        while (img.size() > 216) void'(img.pop_back());
        run(40, 20, -1, 1000, cyc);
        check("t4_fail", 32'(fail), 32'd1);
        check("t4_code", 32'(fail_code), 32'd2);
        check("t4_mem_req", 32'(mem_req), 32'd0);
        check("t4_done", 32'(done), 32'd0);

        // 5) 10-cycle stall without loss, then load_start mid-PRG
        start_load(1'b0);
        build(8'h1A, 8'h00, 8'h00, 1, 1, 5);
        run(40, 10, 316, 1000, cyc);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_fail", 32'(fail), 32'd0);
        check("t5_progress", 32'(wr_count >= 280), 32'd1);
        check("t5_first_addr", first_addr, 32'h0);

        start_load(1'b1);
        check("t5_restart_req", 32'(mem_req), 32'd0);
        check("t5_restart_busy", 32'(busy), 32'd1);
        build(8'h1A, 8'h21, 8'h50, 1, 1, 9);
        void'(img.pop_front());
        run(0, 0, 16 + 16384 + 99, 20000, cyc);
        check("t5_new_first_addr", first_addr, 32'h0);
        check("t5_new_prg_last", prg_last_addr, 32'h003FFF);
        check("t5_new_chr_first", chr_first_addr, 32'h200000);
        check("t5_new_mapper", 32'(mapper), 32'h52);
        check("t5_new_flags", 32'({mirroring, battery}), 32'b10);
        check("t5_in_chr_busy", 32'(busy), 32'd1);

        // 6) asynchronous reset mid-CHR, checked before the next clock edge
        #2;
        resetn = 1'b0;
        #1;
        check("t6_mem_req", 32'(mem_req), 32'd0);
        check("t6_mem_addr", 32'(mem_addr), 32'd0);
        check("t6_mem_data", 32'(mem_data), 32'd0);
        check("t6_fields", 32'({mapper, prg_units, chr_units, mirroring, battery}), 32'd0);
        check("t6_status", 32'({busy, done, fail, fail_code}), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
